// File: rtl/obi_wbuf_if.sv
// OBI_BUS: request/response signal bundle used on both sides of the posted-write buffer.
interface OBI_BUS #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                   req;
    logic                   gnt;
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic                   rvalid;
    logic [DataWidth-1:0]   rdata;
    logic                   err;

    modport Manager (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport Subordinate (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/obi_wbuf.sv
// obi_wbuf: posted-write buffer in front of an OBI SRAM subordinate. Writes are acked one
// cycle after grant and drained from a FIFO; reads are forwarded only once the drain is idle.
module obi_wbuf #(
    parameter int unsigned Depth          = 4,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    OBI_BUS.Subordinate sbr,
    OBI_BUS.Manager     mgr,
    output logic        empty_o,
    output logic        err_o
);
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned BeWidth   = DataWidth / 8;
    localparam int unsigned PtrWidth  = $clog2(Depth);
    localparam int unsigned CntWidth  = $clog2(Depth + 1);
    localparam int unsigned OsWidth   = $clog2(MaxOutstanding + 1);

    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [OsWidth-1:0]  MaxOs    = OsWidth'(MaxOutstanding);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [BeWidth-1:0]   be;
        logic [DataWidth-1:0] wdata;
    } entry_t;

    entry_t              mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [OsWidth-1:0]  os_q, os_d;
    logic                rd_pend_q, rd_pend_d;
    logic                wack_q, wack_d;
    logic                err_q, err_d;

    logic   wr_req, rd_req;
    logic   fifo_full, fifo_empty;
    logic   drain_req, rd_fwd;
    logic   push, pop, rd_grant;
    logic   rd_rsp, wr_rsp;
    entry_t head, push_entry;

    always_comb begin
        wr_req     = sbr.req & sbr.we;
        rd_req     = sbr.req & ~sbr.we;
        fifo_full  = (count_q == DepthCnt);
        fifo_empty = (count_q == '0);
        head       = mem_q[rd_ptr_q];
        push_entry = '{addr: sbr.addr, be: sbr.be, wdata: sbr.wdata};

        // The drain owns the downstream port; a read can only get there once it is idle.
        drain_req = ~fifo_empty & ~rd_pend_q & (os_q < MaxOs);
        rd_fwd    = rd_req & fifo_empty & (os_q == '0) & ~rd_pend_q & ~wack_q;

        push     = rst_ni & wr_req & ~fifo_full;
        pop      = drain_req & mgr.gnt;
        rd_grant = rd_fwd & mgr.gnt;
        rd_rsp   = rd_pend_q & mgr.rvalid;
        wr_rsp   = ~rd_pend_q & mgr.rvalid;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        os_d      = os_q;
        rd_pend_d = rd_pend_q;
        wack_d    = push;
        err_d     = err_q | (wr_rsp & mgr.err);

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CntWidth'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntWidth'(1);
        end

        if (pop && !wr_rsp) begin
            os_d = os_q + OsWidth'(1);
        end else if (!pop && wr_rsp) begin
            os_d = os_q - OsWidth'(1);
        end

        if (rd_grant) begin
            rd_pend_d = 1'b1;
        end else if (rd_rsp) begin
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            os_q      <= '0;
            rd_pend_q <= 1'b0;
            wack_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            os_q      <= os_d;
            rd_pend_q <= rd_pend_d;
            wack_q    <= wack_d;
            err_q     <= err_d;
        end
    end

    // Payload storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign mgr.req   = rst_ni & (drain_req | rd_fwd);
    assign mgr.we    = drain_req;
    assign mgr.addr  = drain_req ? head.addr : sbr.addr;
    assign mgr.be    = drain_req ? head.be : sbr.be;
    assign mgr.wdata = drain_req ? head.wdata : '0;

    assign sbr.gnt    = rst_ni & (wr_req ? ~fifo_full : rd_grant);
    assign sbr.rvalid = rst_ni & (wack_q | rd_rsp);
    assign sbr.rdata  = rd_rsp ? mgr.rdata : '0;
    assign sbr.err    = rd_rsp & mgr.err;

    assign empty_o = fifo_empty & (os_q == '0);
    assign err_o   = err_q;
endmodule
